// File: rtl/rob_alloc_pkg.sv
// Shared types and constants for the ROB / load / store allocation scheduler.
package rob_alloc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FENCE = 2'd1,
        FLUSH = 2'd2
    } alloc_state_t;

    typedef struct packed {
        logic valid;
        logic load;
        logic store;
        logic fence;
    } alloc_req_t;

    // Top bit of an opid marks it valid; the low 15 bits carry the ROB index.
    localparam logic [15:0] OPID_VALID = 16'h8000;

    function automatic logic [15:0] make_opid(input logic [14:0] idx);
        return OPID_VALID | {1'b0, idx};
    endfunction

endpackage

// File: rtl/rob_alloc_id_ring.sv
// Circular ID space: tail pointer plus occupancy, per-lane prefix stamping
// and per-lane free check against the registered count.
module id_ring
    import rob_alloc_pkg::*;
#(
    parameter int size  = 64,
    parameter int idw   = 6,
    parameter int lanes = 4,
    parameter int relw  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [lanes-1:0]       need,
    input  logic [lanes-1:0]       take,
    input  logic [relw-1:0]        rel,
    output logic [lanes*idw-1:0]   ids,
    output logic [lanes-1:0]       ok,
    output logic [$clog2(size):0]  cnt
);

    localparam int cw = $clog2(size) + 1;

    logic [idw-1:0] tail_reg, tail_next;
    logic [cw-1:0]  cnt_reg, cnt_next;
    logic [7:0]     run_cnt;
    logic [7:0]     taken;
    logic [31:0]    sum;

    assign cnt = cnt_reg;

    // Stamp each lane with tail + (needing lanes below it); free check uses the
    // registered count only, so same-cycle releases are not reusable yet.
    always_comb begin
        run_cnt = '0;
        ids     = '0;
        ok      = '0;
        for (int i = 0; i < lanes; i++) begin
            ids[i*idw +: idw] = tail_reg + idw'(run_cnt);
            ok[i]             = (32'(cnt_reg) + 32'(run_cnt) + 32'd1) <= 32'(size);
            run_cnt           = run_cnt + {7'b0, need[i]};
        end
    end

    // Next tail/count: add granted IDs, subtract releases (saturate at 0), clear on flush.
    always_comb begin
        taken = '0;
        for (int i = 0; i < lanes; i++) begin
            if (need[i] && take[i]) taken = taken + 8'd1;
        end
        sum       = 32'(cnt_reg) + 32'(taken);
        tail_next = tail_reg + idw'(taken);
        cnt_next  = (sum < 32'(rel)) ? '0 : cw'(sum - 32'(rel));
        if (clr) begin
            tail_next = '0;
            cnt_next  = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            tail_reg <= tail_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Releasing more than is held is a commit-side bug.
    assert property (@(posedge clk) disable iff (!rst_n) clr || (32'(rel) <= 32'(cnt_reg)));

endmodule

// File: rtl/rob_alloc.sv
// In-order allocation of ROB, load and store IDs for up to dwd decoded ops,
// with fence serialisation against an empty ROB and redirect flush.
module rob_alloc
    import rob_alloc_pkg::*;
#(
    parameter int dwd = 4,
    parameter int cwd = 4,
    parameter int usz = 64,
    parameter int lsz = 16,
    parameter int ssz = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [dwd-1:0]         req_valid,
    input  logic [dwd-1:0]         req_load,
    input  logic [dwd-1:0]         req_store,
    input  logic [dwd-1:0]         req_fence,
    output logic [dwd-1:0]         grant,
    output logic [dwd*16-1:0]      opid,
    output logic [dwd*8-1:0]       ldid,
    output logic [dwd*8-1:0]       stid,
    input  logic [$clog2(cwd):0]   com_num,
    input  logic [$clog2(cwd):0]   com_ld,
    input  logic [$clog2(cwd):0]   com_st,
    input  logic                   redir,
    output logic [$clog2(usz):0]   rob_cnt,
    output logic                   busy
);

    localparam int iw = $clog2(usz);
    localparam int rw = $clog2(cwd) + 1;

    alloc_state_t          fsm_reg;
    alloc_req_t            lane_req [dwd];
    logic [dwd-1:0]        ld_need, st_need;
    logic [dwd-1:0]        rob_ok, ld_ok, st_ok;
    logic [dwd*iw-1:0]     rob_idx;
    logic [$clog2(lsz):0]  ld_cnt;
    logic [$clog2(ssz):0]  st_cnt;
    logic                  run;
    logic                  blocked;
    logic                  lane_ok;
    logic                  fence_stall;

    assign ld_need     = req_valid & req_load;
    assign st_need     = req_valid & req_store;
    assign run         = (fsm_reg == RUN);
    assign busy        = (fsm_reg != RUN);
    assign fence_stall = run && req_valid[0] && req_fence[0] && (rob_cnt != '0);

    generate
        for (genvar gi = 0; gi < dwd; gi++) begin : g_lane
            assign lane_req[gi] = '{valid: req_valid[gi], load: req_load[gi],
                                    store: req_store[gi], fence: req_fence[gi]};
            assign opid[gi*16 +: 16] = grant[gi] ? make_opid(15'(rob_idx[gi*iw +: iw])) : 16'h0;
        end
    endgenerate

    id_ring #(.size(usz), .idw(iw), .lanes(dwd), .relw(rw)) u_rob (
        .clk(clk), .rst_n(rst_n), .clr(redir), .need(req_valid), .take(grant),
        .rel(com_num), .ids(rob_idx), .ok(rob_ok), .cnt(rob_cnt)
    );

    id_ring #(.size(lsz), .idw(8), .lanes(dwd), .relw(rw)) u_ld (
        .clk(clk), .rst_n(rst_n), .clr(redir), .need(ld_need), .take(grant),
        .rel(com_ld), .ids(ldid), .ok(ld_ok), .cnt(ld_cnt)
    );

    id_ring #(.size(ssz), .idw(8), .lanes(dwd), .relw(rw)) u_st (
        .clk(clk), .rst_n(rst_n), .clr(redir), .need(st_need), .take(grant),
        .rel(com_st), .ids(stid), .ok(st_ok), .cnt(st_cnt)
    );

    // In-order grant: first refused valid lane (or a granted fence) blocks the rest.
    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        lane_ok = 1'b0;
        for (int i = 0; i < dwd; i++) begin
            if (lane_req[i].valid) begin
                lane_ok = !redir && run && !blocked && rob_ok[i]
                          && (!lane_req[i].load  || ld_ok[i])
                          && (!lane_req[i].store || st_ok[i])
                          && (!lane_req[i].fence || (i == 0 && rob_cnt == '0));
                grant[i] = lane_ok;
                if (!lane_ok || lane_req[i].fence) blocked = 1'b1;
            end
        end
    end

    // Scheduler state: wait for an empty ROB on fences, one dead cycle after redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg <= RUN;
        end else if (redir) begin
            fsm_reg <= FLUSH;
        end else begin
            case (fsm_reg)
                RUN:     if (fence_stall) fsm_reg <= FENCE;
                FENCE:   if (rob_cnt == '0) fsm_reg <= RUN;
                FLUSH:   fsm_reg <= RUN;
                default: fsm_reg <= RUN;
            endcase
        end
    end

    // Load/store occupancy can never exceed its queue.
    assert property (@(posedge clk) disable iff (!rst_n) (32'(ld_cnt) <= lsz) && (32'(st_cnt) <= ssz));

endmodule

// File: tb/tb_rob_alloc.sv
// Directed bench for rob_alloc: fill/wrap, same-cycle commit, load limits,
// fence serialisation, redirect and asynchronous reset.
module tb_rob_alloc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_load, req_store, req_fence;
    logic [3:0]  grant;
    logic [63:0] opid;
    logic [31:0] ldid, stid;
    logic [2:0]  com_num, com_ld, com_st;
    logic        redir;
    logic [6:0]  rob_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_alloc dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store), .req_fence(req_fence),
        .grant(grant), .opid(opid), .ldid(ldid), .stid(stid),
        .com_num(com_num), .com_ld(com_ld), .com_st(com_st), .redir(redir),
        .rob_cnt(rob_cnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [3:0] s,
                         input logic [3:0] f, input int cn, input int cl, input int cs,
                         input logic rd);
        req_valid = v; req_load = l; req_store = s; req_fence = f;
        com_num = 3'(cn); com_ld = 3'(cl); com_st = 3'(cs); redir = rd;
        #1;
        $display("txn t=%0t v=%b l=%b s=%b f=%b cn=%0d cl=%0d rd=%b -> grant=%b rob_cnt=%0d busy=%b",
                 $time, v, l, s, f, cn, cl, rd, grant, rob_cnt, busy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plain(input logic [3:0] v);
        drive(v, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        tick();
    endtask

    task automatic do_flush();
        drive(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b1);
        tick();
        drive(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        tick();
        tick();
        check("rst_rob_cnt", 32'(rob_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_opid", opid[31:0], 0);
        rst_n = 1'b1;

        // Fill the ROB: 16 cycles of 4 grants, opids run 0x8000..0x803F.
        for (int c = 0; c < 16; c++) begin
            drive(4'hF, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
            check("fill_grant", 32'(grant), 32'hF);
            for (int i = 0; i < 4; i++)
                check("fill_opid", 32'(opid[i*16 +: 16]), 32'h8000 + 32'(4*c + i));
            tick();
        end
        drive(4'hF, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("full_grant", 32'(grant), 0);
        check("full_cnt", 32'(rob_cnt), 64);
        tick();
        check("full_cnt_hold", 32'(rob_cnt), 64);

        // Redirect then one FLUSH cycle with no grants.
        drive(4'hF, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b1);
        check("redir_grant", 32'(grant), 0);
        tick();
        check("flush_busy", 32'(busy), 1);
        check("flush_cnt", 32'(rob_cnt), 0);
        drive(4'hF, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("flush_grant", 32'(grant), 0);
        tick();
        check("flush_exit_busy", 32'(busy), 0);

        // Bring tail and count to 62, then grant+commit in the same cycle.
        for (int c = 0; c < 15; c++) plain(4'hF);
        plain(4'b0011);
        check("cnt62", 32'(rob_cnt), 62);
        drive(4'hF, 4'b0, 4'b0, 4'b0, 4, 0, 0, 1'b0);
        check("wrap_grant", 32'(grant), 32'h3);
        check("wrap_opid0", 32'(opid[15:0]), 32'h803E);
        check("wrap_opid1", 32'(opid[31:16]), 32'h803F);
        check("wrap_opid2", 32'(opid[47:32]), 0);
        tick();
        check("wrap_cnt", 32'(rob_cnt), 60);
        drive(4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("wrap_next_opid", 32'(opid[15:0]), 32'h8000);
        tick();
        check("wrap_next_cnt", 32'(rob_cnt), 61);

        // Load queue limit: 14 loads in flight, pattern lanes {0,1,3} load.
        do_flush();
        for (int c = 0; c < 3; c++) begin
            drive(4'hF, 4'hF, 4'b0, 4'b0, 0, 0, 0, 1'b0);
            tick();
        end
        drive(4'b0011, 4'b0011, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        tick();
        drive(4'hF, 4'b1011, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("ld_grant", 32'(grant), 32'h7);
        check("ld_id0", 32'(ldid[7:0]), 14);
        check("ld_id1", 32'(ldid[15:8]), 15);
        check("ld_id2_next", 32'(ldid[23:16]), 16);
        check("st_id0_next", 32'(stid[7:0]), 0);
        tick();
        check("ld_rob_cnt", 32'(rob_cnt), 17);
        drive(4'b0001, 4'b0001, 4'b0, 4'b0, 0, 1, 0, 1'b0);
        check("ld_full_grant", 32'(grant), 0);
        tick();
        drive(4'b0001, 4'b0001, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("ld_free_grant", 32'(grant), 1);
        check("ld_free_id", 32'(ldid[7:0]), 16);
        tick();

        // Fence: isolated on lane 2, then stalls on lane 0 until the ROB drains.
        do_flush();
        plain(4'hF);
        plain(4'b0001);
        check("fence_cnt5", 32'(rob_cnt), 5);
        drive(4'hF, 4'b0, 4'b0, 4'b0100, 0, 0, 0, 1'b0);
        check("fence_iso_grant", 32'(grant), 32'h3);
        tick();
        drive(4'b0001, 4'b0, 4'b0, 4'b0001, 0, 0, 0, 1'b0);
        check("fence_stall_grant", 32'(grant), 0);
        tick();
        check("fence_busy", 32'(busy), 1);
        drive(4'b0001, 4'b0, 4'b0, 4'b0001, 4, 0, 0, 1'b0);
        check("fence_wait_grant", 32'(grant), 0);
        tick();
        drive(4'b0001, 4'b0, 4'b0, 4'b0001, 3, 0, 0, 1'b0);
        tick();
        check("fence_drained", 32'(rob_cnt), 0);
        check("fence_still_busy", 32'(busy), 1);
        drive(4'hF, 4'b0, 4'b0, 4'b0001, 0, 0, 0, 1'b0);
        check("fence_exit_grant", 32'(grant), 0);
        tick();
        check("fence_run", 32'(busy), 0);
        drive(4'hF, 4'b0, 4'b0, 4'b0001, 0, 0, 0, 1'b0);
        check("fence_alone", 32'(grant), 1);
        check("fence_opid", 32'(opid[15:0]), 32'h8007);
        tick();
        check("fence_cnt1", 32'(rob_cnt), 1);

        // Redirect while waiting on a fence with 7 entries held.
        plain(4'hF);
        plain(4'b0011);
        drive(4'b0001, 4'b0, 4'b0, 4'b0001, 0, 0, 0, 1'b0);
        tick();
        check("rf_busy", 32'(busy), 1);
        check("rf_cnt", 32'(rob_cnt), 7);
        drive(4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b1);
        check("rf_redir_grant", 32'(grant), 0);
        tick();
        drive(4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("rf_flush_grant", 32'(grant), 0);
        check("rf_flush_busy", 32'(busy), 1);
        check("rf_flush_cnt", 32'(rob_cnt), 0);
        tick();
        drive(4'b0001, 4'b0001, 4'b0001, 4'b0, 0, 0, 0, 1'b0);
        check("rf_grant", 32'(grant), 1);
        check("rf_opid", 32'(opid[15:0]), 32'h8000);
        check("rf_ldid", 32'(ldid[7:0]), 0);
        check("rf_stid", 32'(stid[7:0]), 0);
        tick();

        // Asynchronous reset mid-cycle.
        plain(4'hF);
        drive(4'hF, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("ar_pre_cnt", 32'(rob_cnt), 5);
        rst_n = 1'b0;
        #1;
        check("ar_cnt", 32'(rob_cnt), 0);
        check("ar_busy", 32'(busy), 0);
        check("ar_opid", 32'(opid[15:0]), 32'h8000);
        drive(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        rst_n = 1'b1;
        tick();
        drive(4'b0001, 4'b0, 4'b0, 4'b0, 0, 0, 0, 1'b0);
        check("ar_grant", 32'(grant), 1);
        check("ar_first_opid", 32'(opid[15:0]), 32'h8000);
        tick();
        check("ar_post_cnt", 32'(rob_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
